// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotation engine.
// Angles and vectors are Q3.29; the arctangent table is atan(2^-i) * 2^29, rounded.
package cordic_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  localparam int unsigned ATAN_N = 32;

  localparam logic [31:0] ATAN [0:ATAN_N-1] = '{
    32'h1921FB54, 32'h0ED63383, 32'h07D6DD7E, 32'h03FAB753,
    32'h01FF55BB, 32'h00FFEAAE, 32'h007FFD55, 32'h003FFFAB,
    32'h001FFFF5, 32'h000FFFFF, 32'h00080000, 32'h00040000,
    32'h00020000, 32'h00010000, 32'h00008000, 32'h00004000,
    32'h00002000, 32'h00001000, 32'h00000800, 32'h00000400,
    32'h00000200, 32'h00000100, 32'h00000080, 32'h00000040,
    32'h00000020, 32'h00000010, 32'h00000008, 32'h00000004,
    32'h00000002, 32'h00000001, 32'h00000000, 32'h00000000
  };

  localparam logic [31:0] ONE      = 32'h20000000;
  localparam logic [31:0] K_SCALED = 32'h136E9DB3;

  // Beyond the table the angle rounds to zero anyway.
  function automatic logic [31:0] atan_lookup(input int unsigned idx);
    return (idx < ATAN_N) ? ATAN[idx] : 32'h0;
  endfunction

endpackage

// File: rtl/cordic_iter_ctrl_if.sv
// Operand/result handshake bundle for cordic_iter_ctrl.
// slave = engine side, master = source/consumer side.
interface cordic_iter_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int ITERS = 16
);
  localparam int IW = $clog2(ITERS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x_in;
  logic [WIDTH-1:0] y_in;
  logic [WIDTH-1:0] z_in;
  logic             abort;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] x_out;
  logic [WIDTH-1:0] y_out;
  logic [WIDTH-1:0] z_out;
  logic [IW-1:0]    iter;

  modport slave (
    input  in_valid, x_in, y_in, z_in, abort, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, iter
  );

  modport master (
    output in_valid, x_in, y_in, z_in, abort, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, iter
  );

endinterface

// File: rtl/cordic_step.sv
// One CORDIC micro-rotation in rotation mode, purely combinational.
// Direction follows the sign of the incoming residual angle.
module cordic_step #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic signed [WIDTH-1:0] i_x,
  input  logic signed [WIDTH-1:0] i_y,
  input  logic signed [WIDTH-1:0] i_z,
  input  logic        [SHW-1:0]   i_shift,
  input  logic signed [WIDTH-1:0] i_atan,
  output logic signed [WIDTH-1:0] o_x,
  output logic signed [WIDTH-1:0] o_y,
  output logic signed [WIDTH-1:0] o_z
);

  logic signed [WIDTH-1:0] w_xs;
  logic signed [WIDTH-1:0] w_ys;
  logic                    w_neg;

  assign w_xs  = i_x >>> i_shift;
  assign w_ys  = i_y >>> i_shift;
  assign w_neg = i_z[WIDTH-1];

  // Both outputs use the old x and y; sums wrap modulo 2^WIDTH.
  assign o_x = w_neg ? (i_x + w_ys)   : (i_x - w_ys);
  assign o_y = w_neg ? (i_y - w_xs)   : (i_y + w_xs);
  assign o_z = w_neg ? (i_z + i_atan) : (i_z - i_atan);

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC rotation engine: one shared step, ITERS cycles per job,
// valid/ready on both sides and a synchronous abort that drops the job.
module cordic_iter_ctrl
  import cordic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = 16
) (
  input logic               clk,
  input logic               rst_n,
  cordic_iter_ctrl_if.slave bus
);

  localparam int IW = $clog2(ITERS + 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic signed [WIDTH-1:0] r_x;
  logic signed [WIDTH-1:0] r_y;
  logic signed [WIDTH-1:0] r_z;
  logic        [IW-1:0]    r_iter;
  logic signed [WIDTH-1:0] w_x_nxt;
  logic signed [WIDTH-1:0] w_y_nxt;
  logic signed [WIDTH-1:0] w_z_nxt;
  logic signed [WIDTH-1:0] w_atan;
  logic                    w_last;

  assign w_atan = WIDTH'(atan_lookup(int'(r_iter)));
  assign w_last = (r_iter == IW'(ITERS - 1));

  cordic_step #(
    .WIDTH (WIDTH),
    .SHW   (IW)
  ) u_step (
    .i_x     (r_x),
    .i_y     (r_y),
    .i_z     (r_z),
    .i_shift (r_iter),
    .i_atan  (w_atan),
    .o_x     (w_x_nxt),
    .o_y     (w_y_nxt),
    .o_z     (w_z_nxt)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Abort outranks every other transition but is ignored while idle.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)                    w_state_nxt = RUN;
      RUN:     if (bus.abort)                       w_state_nxt = IDLE;
               else if (w_last)                     w_state_nxt = HOLD;
      HOLD:    if (bus.abort || bus.out_ready)      w_state_nxt = IDLE;
      default:                                      w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_z    <= '0;
      r_iter <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_x    <= bus.x_in;
          r_y    <= bus.y_in;
          r_z    <= bus.z_in;
          r_iter <= '0;
        end
        RUN: if (bus.abort) begin
          r_iter <= '0;
        end else begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_z    <= w_z_nxt;
          r_iter <= r_iter + IW'(1);
        end
        HOLD: if (bus.abort || bus.out_ready) r_iter <= '0;
        default: r_iter <= '0;
      endcase
    end
  end

  // Working registers are the result; they only move in RUN, so HOLD is stable.
  assign bus.x_out = r_x;
  assign bus.y_out = r_y;
  assign bus.z_out = r_z;
  assign bus.iter  = r_iter;

endmodule
